// File: rtl/fp16_to_int16_pipe.sv
// Two-stage binary16 -> int16 converter with saturation, status flags and valid/ready flow control.
// Stage 1 decodes the operand into an integer part plus guard/round/sticky bits; stage 2 rounds, signs and saturates.
module fp16_to_int16_pipe #(
  parameter int ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] fp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] int_out,
  output logic        flag_overflow,
  output logic        flag_invalid,
  output logic        flag_inexact
);

  // Handshake: a stage transfers on valid && ready; each stage may load while its
  // current content moves on, so in_ready = !s1_valid || s2_ready is combinational.
  typedef enum logic [1:0] {CLS_ZERO, CLS_FIN, CLS_INF, CLS_NAN} cls_e;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q, s1_sign_d;
  cls_e        s1_cls_q, s1_cls_d;
  logic [15:0] s1_mag_q, s1_mag_d;
  logic        s1_guard_q, s1_guard_d;
  logic        s1_round_q, s1_round_d;
  logic        s1_sticky_q, s1_sticky_d;

  logic        s2_valid_q, s2_valid_d;
  logic [15:0] s2_int_q, s2_int_d;
  logic        s2_ovf_q, s2_ovf_d;
  logic        s2_inv_q, s2_inv_d;
  logic        s2_inx_q, s2_inx_d;

  logic        s2_ready;
  logic [4:0]  dec_exp;
  logic [9:0]  dec_mant;
  logic [3:0]  dec_shamt;
  logic [25:0] dec_shifted;
  cls_e        dec_cls;
  logic [15:0] dec_mag;
  logic        dec_guard, dec_round, dec_sticky;

  logic        rnd_inc;
  logic [16:0] rnd_mag;
  logic        rnd_lost;
  logic [15:0] res_int;
  logic        res_ovf, res_inv, res_inx;

  assign s2_ready = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;

  // Decode: {1,mant} with 10 fraction bits, shifted left by exp-15 for exp 15..30.
  always_comb begin
    dec_exp     = fp_in[14:10];
    dec_mant    = fp_in[9:0];
    dec_shamt   = 4'(dec_exp - 5'd15);
    dec_shifted = {15'd0, 1'b1, dec_mant} << dec_shamt;
    dec_cls     = CLS_ZERO;
    dec_mag     = 16'd0;
    dec_guard   = 1'b0;
    dec_round   = 1'b0;
    dec_sticky  = 1'b0;
    if (dec_exp == 5'd31) begin
      dec_cls = (dec_mant != 10'd0) ? CLS_NAN : CLS_INF;
    end else if (dec_exp == 5'd0) begin
      dec_sticky = (dec_mant != 10'd0);
    end else if (dec_exp < 5'd15) begin
      dec_cls = CLS_FIN;
      if (dec_exp == 5'd14) begin
        dec_guard  = 1'b1;
        dec_round  = dec_mant[9];
        dec_sticky = (dec_mant[8:0] != 9'd0);
      end else begin
        dec_sticky = 1'b1;
      end
    end else begin
      dec_cls    = CLS_FIN;
      dec_mag    = dec_shifted[25:10];
      dec_guard  = dec_shifted[9];
      dec_round  = dec_shifted[8];
      dec_sticky = (dec_shifted[7:0] != 8'd0);
    end
  end

  // Round, apply sign, saturate. Only -32768 exactly survives a 16-bit magnitude of 32768.
  always_comb begin
    rnd_inc  = (ROUND_MODE == 1) && s1_guard_q && (s1_round_q || s1_sticky_q || s1_mag_q[0]);
    rnd_mag  = {1'b0, s1_mag_q} + {16'd0, rnd_inc};
    rnd_lost = s1_guard_q || s1_round_q || s1_sticky_q;
    res_int  = 16'd0;
    res_ovf  = 1'b0;
    res_inv  = 1'b0;
    res_inx  = 1'b0;
    case (s1_cls_q)
      CLS_NAN: res_inv = 1'b1;
      CLS_INF: begin
        res_int = s1_sign_q ? 16'h8000 : 16'h7FFF;
        res_ovf = 1'b1;
      end
      default: begin
        if (rnd_mag > 17'd32767) begin
          if (s1_sign_q && rnd_mag == 17'd32768 && !rnd_lost) begin
            res_int = 16'h8000;
          end else begin
            res_int = s1_sign_q ? 16'h8000 : 16'h7FFF;
            res_ovf = 1'b1;
          end
        end else begin
          res_int = s1_sign_q ? (~rnd_mag[15:0] + 16'd1) : rnd_mag[15:0];
          res_inx = rnd_lost;
        end
      end
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_cls_d    = s1_cls_q;
    s1_mag_d    = s1_mag_q;
    s1_guard_d  = s1_guard_q;
    s1_round_d  = s1_round_q;
    s1_sticky_d = s1_sticky_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d   = fp_in[15];
        s1_cls_d    = dec_cls;
        s1_mag_d    = dec_mag;
        s1_guard_d  = dec_guard;
        s1_round_d  = dec_round;
        s1_sticky_d = dec_sticky;
      end
    end
    s2_valid_d = s2_valid_q;
    s2_int_d   = s2_int_q;
    s2_ovf_d   = s2_ovf_q;
    s2_inv_d   = s2_inv_q;
    s2_inx_d   = s2_inx_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_int_d = res_int;
        s2_ovf_d = res_ovf;
        s2_inv_d = res_inv;
        s2_inx_d = res_inx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_cls_q    <= CLS_ZERO;
      s1_mag_q    <= 16'd0;
      s1_guard_q  <= 1'b0;
      s1_round_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_int_q    <= 16'd0;
      s2_ovf_q    <= 1'b0;
      s2_inv_q    <= 1'b0;
      s2_inx_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_cls_q    <= s1_cls_d;
      s1_mag_q    <= s1_mag_d;
      s1_guard_q  <= s1_guard_d;
      s1_round_q  <= s1_round_d;
      s1_sticky_q <= s1_sticky_d;
      s2_valid_q  <= s2_valid_d;
      s2_int_q    <= s2_int_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_inv_q    <= s2_inv_d;
      s2_inx_q    <= s2_inx_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign int_out       = s2_int_q;
  assign flag_overflow = s2_ovf_q;
  assign flag_invalid  = s2_inv_q;
  assign flag_inexact  = s2_inx_q;

endmodule

// File: tb/tb_fp16_to_int16_pipe.sv
// Bench for fp16_to_int16_pipe: truncating and round-to-nearest instances driven in lockstep,
// each checked against an exact arithmetic model through its own expected queue.
module tb_fp16_to_int16_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] fp_in;
  logic [1:0]  in_ready_v, out_valid_v, ovf_v, inv_v, inx_v;
  logic [15:0] int_v [2];

  int total = 0;
  int bad = 0;
  logic [18:0] exp_q0[$];
  logic [18:0] exp_q1[$];
  logic [1:0]  held_v;
  logic [19:0] held_val [2];

  always #5 clk = ~clk;

  fp16_to_int16_pipe #(.ROUND_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]), .fp_in(fp_in),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .int_out(int_v[0]),
    .flag_overflow(ovf_v[0]), .flag_invalid(inv_v[0]), .flag_inexact(inx_v[0])
  );

  fp16_to_int16_pipe #(.ROUND_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]), .fp_in(fp_in),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .int_out(int_v[1]),
    .flag_overflow(ovf_v[1]), .flag_invalid(inv_v[1]), .flag_inexact(inx_v[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
    end
  endtask

  // Exact model: value scaled by 2^24 as an integer, then {int, overflow, invalid, inexact}.
  function automatic logic [18:0] model(input logic [15:0] x, input int mode);
    int    e;
    longint m, v, q, f, sv;
    logic  inx;
    e = int'(x[14:10]);
    m = longint'(x[9:0]);
    if (e == 31 && m != 0) return {16'h0000, 3'b010};
    if (e == 31) return {(x[15] ? 16'h8000 : 16'h7FFF), 3'b100};
    v = (e == 0) ? m : ((1024 + m) << (e - 1));
    q = v >> 24;
    f = v & ((64'sd1 << 24) - 1);
    if (mode == 1 && (f > (64'sd1 << 23) || (f == (64'sd1 << 23) && q[0]))) q = q + 1;
    inx = (f != 0);
    sv = x[15] ? -q : q;
    if (sv > 32767 || sv < -32768) return {(x[15] ? 16'h8000 : 16'h7FFF), 3'b100};
    return {sv[15:0], 2'b00, inx};
  endfunction

  // Scoreboard: compares at the falling edge, where the handshake for the next rising edge is settled.
  always @(negedge clk) begin
    logic [19:0] got;
    logic [18:0] e;
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      held_v = 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        got = {out_valid_v[k], int_v[k], ovf_v[k], inv_v[k], inx_v[k]};
        if (held_v[k]) check($sformatf("stall_hold%0d", k), 32'(got), 32'(held_val[k]));
        if (out_valid_v[k] && out_ready) begin
          if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            check($sformatf("spurious_out%0d", k), 32'(got), 32'd0);
          end else begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("result_m%0d", k), 32'(got[18:0]), 32'(e));
          end
        end
        held_v[k] = out_valid_v[k] && !out_ready;
        held_val[k] = got;
        if (in_valid && in_ready_v[k]) begin
          if (k == 0) exp_q0.push_back(model(fp_in, 0));
          else        exp_q1.push_back(model(fp_in, 1));
        end
      end
    end
  end

  task automatic idle(input int n, input logic r);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = r;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
      idle(1, 1'b1);
      n++;
    end
    @(negedge clk);
    check("drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
  endtask

  // Single sample with out_ready held high: result must appear on the second edge after accept.
  task automatic lat_one(input logic [15:0] x);
    @(posedge clk); #1;
    in_valid = 1'b1; fp_in = x; out_ready = 1'b1;
    @(negedge clk);
    check("lat_accept", 32'(in_ready_v), 32'h3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_early", 32'(out_valid_v), 32'h0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid_v), 32'h3);
  endtask

  task automatic push_sample(input logic [15:0] x, input int vp, input int rp);
    int   n;
    logic acc;
    while ($urandom_range(99) >= vp) begin
      @(posedge clk); #1;
      in_valid = 1'b0; fp_in = 16'($urandom); out_ready = ($urandom_range(99) < rp);
    end
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(posedge clk); #1;
      in_valid = 1'b1; fp_in = x; out_ready = ($urandom_range(99) < rp);
      @(negedge clk);
      acc = in_ready_v[0];
      n++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  localparam int NPIN = 20;
  logic [15:0] pin_x [NPIN];
  int          pin_m [NPIN];
  logic [18:0] pin_e [NPIN];

  initial begin
    pin_x[0]  = 16'h3C00; pin_m[0]  = 0; pin_e[0]  = {16'h0001, 3'b000};
    pin_x[1]  = 16'hC500; pin_m[1]  = 0; pin_e[1]  = {16'hFFFB, 3'b000};
    pin_x[2]  = 16'h0000; pin_m[2]  = 1; pin_e[2]  = {16'h0000, 3'b000};
    pin_x[3]  = 16'h8000; pin_m[3]  = 1; pin_e[3]  = {16'h0000, 3'b000};
    pin_x[4]  = 16'h3E00; pin_m[4]  = 0; pin_e[4]  = {16'h0001, 3'b001};
    pin_x[5]  = 16'h3E00; pin_m[5]  = 1; pin_e[5]  = {16'h0002, 3'b001};
    pin_x[6]  = 16'h4100; pin_m[6]  = 0; pin_e[6]  = {16'h0002, 3'b001};
    pin_x[7]  = 16'h4100; pin_m[7]  = 1; pin_e[7]  = {16'h0002, 3'b001};
    pin_x[8]  = 16'h3800; pin_m[8]  = 0; pin_e[8]  = {16'h0000, 3'b001};
    pin_x[9]  = 16'h3800; pin_m[9]  = 1; pin_e[9]  = {16'h0000, 3'b001};
    pin_x[10] = 16'hBA00; pin_m[10] = 0; pin_e[10] = {16'h0000, 3'b001};
    pin_x[11] = 16'hBA00; pin_m[11] = 1; pin_e[11] = {16'hFFFF, 3'b001};
    pin_x[12] = 16'h7C00; pin_m[12] = 1; pin_e[12] = {16'h7FFF, 3'b100};
    pin_x[13] = 16'hFC00; pin_m[13] = 0; pin_e[13] = {16'h8000, 3'b100};
    pin_x[14] = 16'h7E00; pin_m[14] = 1; pin_e[14] = {16'h0000, 3'b010};
    pin_x[15] = 16'hF800; pin_m[15] = 0; pin_e[15] = {16'h8000, 3'b000};
    pin_x[16] = 16'h7800; pin_m[16] = 1; pin_e[16] = {16'h7FFF, 3'b100};
    pin_x[17] = 16'h77FF; pin_m[17] = 1; pin_e[17] = {16'h7FF0, 3'b000};
    pin_x[18] = 16'h3A01; pin_m[18] = 1; pin_e[18] = {16'h0001, 3'b001};
    pin_x[19] = 16'h0001; pin_m[19] = 1; pin_e[19] = {16'h0000, 3'b001};
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, c;
    logic [15:0] bp_x [8];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fp_in = 16'h0000;
    held_v = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid_v), 32'h0);
    check("reset_int_out", 32'({int_v[0], int_v[1]}), 32'h0);
    check("reset_flags", 32'({ovf_v, inv_v, inx_v}), 32'h0);
    check("reset_in_ready", 32'(in_ready_v), 32'h3);

    for (int i = 0; i < NPIN; i++)
      check($sformatf("model_pin%0d", i), 32'(model(pin_x[i], pin_m[i])), 32'(pin_e[i]));

    for (int i = 0; i < NPIN; i++) lat_one(pin_x[i]);
    wait_drain();

    // Backpressure: out_ready low for cycles 3..5 while 8 samples stream in.
    for (int i = 0; i < 8; i++) bp_x[i] = 16'h4000 + 16'(i * 16'h0180);
    idx = 0; c = 0;
    while (idx < 8 && c < 100) begin
      @(posedge clk); #1;
      in_valid = 1'b1; fp_in = bp_x[idx]; out_ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        check("bp_in_ready_low", 32'(in_ready_v), 32'h0);
        check("bp_out_valid", 32'(out_valid_v), 32'h3);
      end
      if (in_ready_v[0]) idx++;
      c++;
    end
    wait_drain();

    // Full throughput: continuous valid with out_ready high never stalls.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; fp_in = 16'($urandom); out_ready = 1'b1;
      @(negedge clk);
      check("thru_in_ready", 32'(in_ready_v), 32'h3);
      if (i >= 2) check("thru_out_valid", 32'(out_valid_v), 32'h3);
    end
    wait_drain();

    // Reset with two samples in flight.
    @(posedge clk); #1;
    in_valid = 1'b1; fp_in = 16'h4500; out_ready = 1'b0;
    @(posedge clk); #1;
    fp_in = 16'hC600;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_flush_valid", 32'(out_valid_v), 32'h0);
    check("rst_flush_ready", 32'(in_ready_v), 32'h3);
    idle(6, 1'b1);
    @(negedge clk);
    check("rst_no_stale", 32'(out_valid_v), 32'h0);

    for (int i = 0; i < 10000; i++) push_sample(16'($urandom), 70, 60);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp16_to_int16_pipe.md
Name: fp16_to_int16_pipe

Overview:
Two-stage pipelined converter from IEEE-754 binary16 to 16-bit signed two's-complement integer, with valid/ready flow control on both sides. It sits downstream of the int16-to-fp16 conversion and the fp16 arithmetic datapath, returning fp16 results to the integer domain. Out-of-range values saturate, and per-sample status flags are reported. Rounding mode is fixed at elaboration.

Parameters:
ROUND_MODE, 0, 0 = truncate toward zero; 1 = round to nearest, ties to even

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  fp_in is valid
in_ready  output  1  block accepts fp_in this cycle
fp_in  input  16  binary16 operand {sign, exp[4:0], mant[9:0]}
out_valid  output  1  int_out and flags are valid
out_ready  input  1  consumer accepts int_out this cycle
int_out  output  16  signed integer result
flag_overflow  output  1  result saturated (|value| out of range, or ±Inf)
flag_invalid  output  1  input was NaN
flag_inexact  output  1  nonzero fraction was discarded by rounding or truncation

Behaviour:
- Reset: s1_valid=0, s2_valid=0, out_valid=0, int_out=0, all flags=0. in_ready is 1 in the cycle after rst deasserts. Any in-flight samples are dropped.
- Handshake:
  - Transfer occurs on valid&&ready.
  - s2_ready = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_ready (combinational).
  - Full throughput of 1 sample/cycle. Latency is 2 cycles from input accept to out_valid with no stall.
  - Ordering is preserved. No sample is lost or duplicated under any out_ready pattern.
  - While out_valid=1 && out_ready=0, int_out and flags hold stable.
  - in_valid is not required to stay high; the block never samples fp_in unless in_ready=1.
- Stage 1 (decode): register sign, class (zero/sub, normal, inf, nan), and a 26-bit fixed-point magnitude {1,mant} shifted by (exp-15). Only exp 15..30 produce a nonzero integer part. Guard, round and sticky bits are derived from the discarded fraction.
- Stage 2 (round/sign/saturate), in priority order:
  - NaN (exp=31, mant!=0): int_out=0x0000, invalid=1.
  - Inf (exp=31, mant=0): int_out=0x7FFF (+) or 0x8000 (-), overflow=1.
  - exp=0 (zero or subnormal): int_out=0. inexact=1 iff mant!=0.
  - exp<15: integer part 0.
    - ROUND_MODE=0: result 0.
    - ROUND_MODE=1: exp=14 with mant!=0 rounds to magnitude 1; exactly 0.5 rounds to 0. Values below 0.5 give 0.
    - inexact=1 in both modes.
  - 15<=exp<=29: magnitude = integer part, plus round increment in mode 1 (guard && (round||sticky||lsb)). Apply sign by two's-complement negate. inexact = any discarded fraction bit set.
  - exp=30 (magnitude >= 32768):
    - If sign=1 and mant=0: int_out=0x8000 exact.
    - Otherwise saturate to 0x7FFF or 0x8000 with overflow=1.
  - Negative zero produces 0x0000.
  - At most one of overflow/invalid is set. inexact=0 whenever overflow or invalid is set.
- Max finite in-range magnitude is 32752 (exp=29, mant=0x3FF), which is exact; rounding never carries past 15 bits below exp=30.
- Simultaneous events: stage 1 capture and stage 2 drain occur in the same cycle when out_ready=1. Reset dominates any handshake in the same cycle.

Test Plan:
- Basic, out_ready=1:
  - 0x3C00 -> 1.
  - 0xC500 -> 0xFFFB (-5).
  - 0x0000 and 0x8000 -> 0.
  - Each appears exactly 2 cycles after accept, flags all 0.
- Rounding:
  - 0x3E00 (1.5) -> 1 with inexact (mode 0), 2 with inexact (mode 1).
  - 0x4100 (2.5) -> 2 inexact in both modes.
  - 0x3800 (0.5) -> 0 inexact in both modes.
  - 0xBA00 (-0.75) -> 0 (mode 0), 0xFFFF (mode 1), inexact.
- Specials and range:
  - 0x7C00 -> 0x7FFF overflow.
  - 0xFC00 -> 0x8000 overflow.
  - 0x7E00 -> 0x0000 invalid.
  - 0xF800 -> 0x8000, no flags.
  - 0x7800 -> 0x7FFF overflow.
  - 0x77FF -> 32752 (0x7FF0), no flags.
- Backpressure:
  - Stream 8 consecutive values with out_ready low for 3 cycles mid-stream.
  - in_ready drops after 2 samples are buffered.
  - Outputs hold stable while stalled.
  - All 8 results emerge in order with no loss or duplication.
- Random out_ready and in_valid toggling over 10k samples, checked against a reference model; full throughput when out_ready=1.
- Reset with 2 samples in flight -> out_valid=0 the next cycle, in_ready=1, no stale output after reset.
